regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back end of the ALU result bus: captures the destination register index when any ALU unit is enabled, samples the shared `rd_value` bus one cycle later (after the ALU has registered its result), and commits it into the 32-entry integer register file. Also provides the two combinational read ports (`rs1_value`, `rs2_value`) consumed by the ALU units, and a retired-write counter. Sits between the ALU unit array and the decode stage.

## Interface
- `XLEN`, 32, data width of registers and result bus
- `NUM_REGS`, 32, number of architectural registers; index width is log2(`NUM_REGS`) = 5
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wb_enable`  in  1  OR of all ALU unit enables this cycle; result appears on `rd_value` next cycle
- `rd_index`  in  5  destination register index, valid with `wb_enable`
- `rd_value`  in  XLEN  shared ALU result bus (undriven when no unit enabled)
- `rs1_index`  in  5  read port 1 index
- `rs2_index`  in  5  read port 2 index
- `rs1_value`  out  XLEN  read port 1 data, combinational
- `rs2_value`  out  XLEN  read port 2 data, combinational
- `write_done`  out  1  one-cycle pulse on the cycle the commit occurs
- `write_count`  out  32  number of commits since reset, wraps modulo 2^32

## Operation
- Stage A (capture): at edge ending cycle N with `wb_enable`=1, set `pend_valid`=1, `pend_index`=`rd_index`; with `wb_enable`=0, `pend_valid`=0.
- Stage B (commit): during cycle N+1, `pend_valid`=1 means `rd_value` is driven. At edge ending N+1: `regs[pend_index]` <= `rd_value` unless `pend_index`=0; `write_count` increments.
- `write_done` = `pend_valid` (combinational from the stage register), high exactly during cycle N+1.
- x0: writes to index 0 are discarded. `write_done` still pulses and `write_count` still increments. Reads of index 0 always return 0.
- Back-to-back enables on consecutive cycles are fully pipelined: a capture and a commit happen on the same edge, one result per cycle, with no stall.
- `rd_value` is never sampled when `pend_valid`=0. Undriven bus values must never reach `regs`.
- Reads: `rs*_value` = `regs[rs*_index]`, with 0 for index 0. Without bypass, a value committed at the end of N+1 is readable from cycle N+2.
- Same index written twice back-to-back: the later commit wins, in program order.

## Timing
- Reset, applied at the edge where `reset`=1: `pend_valid`=0, `pend_index`=0, all `regs`=0, `write_count`=0. `write_done` is 0 in the following cycle. `rs*_value` read 0.
- Reset has priority over commit and capture on the same edge. A pending result is dropped, with no write and no count.
- Latency: `wb_enable` in cycle N, then commit at the end of N+1, then visible at N+2 (N+1 with bypass).
- `write_count` wraps from 0xFFFF_FFFF to 0 with no flag.

## Configuration
- `REGFILE_WRITEBACK_BYPASS_EN` defined: during a cycle with `pend_valid`=1 and `rs*_index`==`pend_index`!=0, the read port returns `rd_value` instead of `regs`. Results are visible one cycle earlier.
- Not defined: read ports return only `regs`. The decode stage must not issue a dependent read in cycle N+1.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `REG_INDEX_W`=5, `REG_ZERO`=5'd0, typedef `reg_index_t` (5-bit), typedef `xlen_t`.
- One sub-module: `regfile_read_port`, instantiated twice. It contains the index mux, x0 forcing, and optional bypass compare.
- Top holds the stage register, the register array, and the counter.

## Test plan
- Reset, then read x1..x31 → all 0, `write_count`=0, `write_done`=0.
- `wb_enable`=1, `rd_index`=5; next cycle `rd_value`=0xDEAD_B000 → `write_done` pulses in that cycle. Next cycle x5 reads 0xDEAD_B000, `write_count`=1.
- Write x0 with 0x1234_5678 → x0 reads 0, `write_done` pulses, `write_count` increments.
- Three consecutive enables to x3/x4/x3 with values 1/2/3 → three consecutive `write_done` pulses; x3=3, x4=2, `write_count`=3.
- Assert `reset` in the commit cycle of a pending write of x7=0xAAAA_AAAA → x7 stays 0, `write_count`=0.
- With bypass: `rs1_index`=9 during commit of x9=0x0000_00FF → `rs1_value`=0xFF in the same cycle. Without bypass: the old value (0) that cycle, then 0xFF the next.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: data width, architectural register count and the
// register index / data typedefs used across the write-back slice.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int NUM_REGS    = 32;
  localparam int REG_INDEX_W = $clog2(NUM_REGS);

  localparam logic [REG_INDEX_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_INDEX_W-1:0] reg_index_t;
  typedef logic [XLEN-1:0]        xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: index mux, x0 forced to zero and,
// when REGFILE_WRITEBACK_BYPASS_EN is defined, a forward of the in-flight result.
module regfile_read_port
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0]        regs [NUM_REGS],
  input  logic [REG_INDEX_W-1:0] index,
`ifdef REGFILE_WRITEBACK_BYPASS_EN
  input  logic                   pend_valid,
  input  logic [REG_INDEX_W-1:0] pend_index,
  input  logic [XLEN-1:0]        rd_value,
`endif
  output logic [XLEN-1:0]        value
);

  always_comb begin
    value = regs[index];
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    // The bus value being committed this cycle is newer than the array entry.
    if (pend_valid && (pend_index == index)) begin
      value = rd_value;
    end
`endif
    if (index == REG_ZERO) begin
      value = '0;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: captures rd_index with wb_enable, commits rd_value one cycle
// later into the 32-entry register file, counts commits and serves two read ports.
// Optional same-cycle forwarding is enabled by REGFILE_WRITEBACK_BYPASS_EN.
module regfile_writeback
  import riscv_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_enable,
  input  logic [REG_INDEX_W-1:0] rd_index,
  input  logic [XLEN-1:0]        rd_value,
  input  logic [REG_INDEX_W-1:0] rs1_index,
  input  logic [REG_INDEX_W-1:0] rs2_index,
  output logic [XLEN-1:0]        rs1_value,
  output logic [XLEN-1:0]        rs2_value,
  output logic                   write_done,
  output logic [31:0]            write_count
);

  logic                   pend_valid_reg;
  logic [REG_INDEX_W-1:0] pend_index_reg;
  logic [31:0]            write_count_reg;
  logic [XLEN-1:0]        regs_reg [NUM_REGS];

  // rd_value is only looked at while pend_valid_reg is set, so an undriven
  // bus never reaches the array.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_reg  <= 1'b0;
      pend_index_reg  <= REG_ZERO;
      write_count_reg <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      pend_valid_reg <= wb_enable;
      if (wb_enable) begin
        pend_index_reg <= rd_index;
      end
      if (pend_valid_reg) begin
        write_count_reg <= write_count_reg + 32'd1;
        if (pend_index_reg != REG_ZERO) begin
          regs_reg[pend_index_reg] <= rd_value;
        end
      end
    end
  end

  assign write_done  = pend_valid_reg;
  assign write_count = write_count_reg;

  logic [REG_INDEX_W-1:0] rs_index [2];
  logic [XLEN-1:0]        rs_value [2];

  assign rs_index[0] = rs1_index;
  assign rs_index[1] = rs2_index;
  assign rs1_value   = rs_value[0];
  assign rs2_value   = rs_value[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
    regfile_read_port u_read_port (
      .regs       (regs_reg),
      .index      (rs_index[gi]),
`ifdef REGFILE_WRITEBACK_BYPASS_EN
      .pend_valid (pend_valid_reg),
      .pend_index (pend_index_reg),
      .rd_value   (rd_value),
`endif
      .value      (rs_value[gi])
    );
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, hand-written
// bypass/x0 sequences and a randomized phase checked against a queue-based model.
module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_enable;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        write_done;
  logic [31:0] write_count;

  regfile_writeback dut (
    .clock       (clock),
    .reset       (reset),
    .wb_enable   (wb_enable),
    .rd_index    (rd_index),
    .rd_value    (rd_value),
    .rs1_index   (rs1_index),
    .rs2_index   (rs2_index),
    .rs1_value   (rs1_value),
    .rs2_value   (rs2_value),
    .write_done  (write_done),
    .write_count (write_count)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: architectural register contents, commit count and the
  // destination indices announced but not yet committed.
  logic [31:0] m_regs [32];
  int unsigned m_count;
  int          pend_q[$];

  typedef struct {
    bit          rst;
    bit          en;
    logic [4:0]  idx;
    logic [31:0] val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    bit          edone;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_vec(input bit rst, input bit en, input logic [4:0] idx,
                         input logic [31:0] val, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input bit edone, input logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.en = en; v.idx = idx; v.val = val; v.rs1 = rs1; v.rs2 = rs2;
    v.e1 = e1; v.e2 = e2; v.edone = edone; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit en, input logic [4:0] idx,
                       input logic [31:0] val, input logic [4:0] rs1, input logic [4:0] rs2);
    reset = rst; wb_enable = en; rd_index = idx; rd_value = val;
    rs1_index = rs1; rs2_index = rs2;
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    int idx;
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_count = 0;
      pend_q.delete();
    end else begin
      if (pend_q.size() > 0) begin
        idx = pend_q.pop_front();
        if (idx != 0) m_regs[idx] = rd_value;
        m_count++;
      end
      if (wb_enable) pend_q.push_back(int'(rd_index));
    end
    cyc++;
    #1;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    if (pend_q.size() > 0 && pend_q[0] == int'(idx)) return rd_value;
`endif
    return m_regs[idx];
  endfunction

  task automatic show();
    $display("cyc %0d rst=%0b en=%0b rd=%0d val=%h rs1[%0d]=%h rs2[%0d]=%h done=%0b cnt=%0d",
             cyc, reset, wb_enable, rd_index, rd_value, rs1_index, rs1_value,
             rs2_index, rs2_value, write_done, write_count);
  endtask

  task automatic check_now(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input bit edone, input logic [31:0] ecnt);
    @(negedge clock);
    show();
    chk({tag, ".rs1"},   rs1_value, e1);
    chk({tag, ".rs2"},   rs2_value, e2);
    chk({tag, ".done"},  {31'd0, write_done}, {31'd0, edone});
    chk({tag, ".count"}, write_count, ecnt);
    tick();
  endtask

  localparam logic [31:0] DEAD = 32'hDEAD_B000;

  initial begin
    logic [4:0] r1, r2;

    // Directed program: each row is one cycle with the outputs expected during it.
    add_vec(0, 1, 5, 32'h0,         5, 0, 0,    0,    0, 0);
    add_vec(0, 0, 0, DEAD,          1, 2, 0,    0,    1, 0);
    add_vec(0, 0, 0, 32'h0,         5, 0, DEAD, 0,    0, 1);
    add_vec(0, 1, 0, 32'h0,         0, 5, 0,    DEAD, 0, 1);
    add_vec(0, 0, 0, 32'h1234_5678, 0, 1, 0,    0,    1, 1);
    add_vec(0, 1, 3, 32'h0,         0, 0, 0,    0,    0, 2);
    add_vec(0, 1, 4, 32'h1,         5, 0, DEAD, 0,    1, 2);
    add_vec(0, 1, 3, 32'h2,         3, 0, 1,    0,    1, 3);
    add_vec(0, 0, 0, 32'h3,         4, 0, 2,    0,    1, 4);
    add_vec(0, 0, 0, 32'h0,         3, 4, 3,    2,    0, 5);
    add_vec(0, 1, 7, 32'h0,         0, 0, 0,    0,    0, 5);
    add_vec(1, 0, 0, 32'hAAAA_AAAA, 3, 5, 3,    DEAD, 1, 5);
    add_vec(0, 0, 0, 32'h0,         7, 3, 0,    0,    0, 0);
    add_vec(0, 0, 0, 32'h0,         5, 4, 0,    0,    0, 0);

    drive(1, 0, 0, 32'h0, 0, 0);
    tick();
    tick();

    // Whole file reads zero straight after reset.
    for (int i = 1; i < 32; i += 2) begin
      drive(0, 0, 0, $urandom, 5'(i), 5'(i + 1));
      check_now("reset_read", 0, 0, 0, 0);
    end

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].idx, vecs[k].val, vecs[k].rs1, vecs[k].rs2);
      check_now($sformatf("vec%0d", k), vecs[k].e1, vecs[k].e2, vecs[k].edone, vecs[k].ecnt);
    end

    // Read-during-commit of x9, then x0 must not be forwarded.
    drive(0, 1, 9, 32'h0, 9, 0);
    check_now("byp_issue", 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0000_00FF, 9, 0);
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    check_now("byp_commit", 32'hFF, 0, 1, 0);
`else
    check_now("byp_commit", 32'h0, 0, 1, 0);
`endif
    drive(0, 1, 0, 32'h0, 9, 0);
    check_now("byp_after", 32'hFF, 0, 0, 1);
    drive(0, 0, 0, 32'h55, 0, 9);
    check_now("x0_commit", 0, 32'hFF, 1, 1);
    drive(0, 0, 0, 32'h0, 0, 9);
    check_now("x0_after", 0, 32'hFF, 0, 2);

    // Randomized traffic against the model; rd_value is random garbage when idle.
    for (int n = 0; n < 300; n++) begin
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      if (pend_q.size() > 0 && ($urandom % 3) == 0) r1 = 5'(pend_q[0]);
      if (pend_q.size() > 0 && ($urandom % 4) == 0) r2 = 5'(pend_q[0]);
      drive(($urandom % 64) == 0, ($urandom % 3) != 0, 5'($urandom % 8), $urandom, r1, r2);
      check_now("rand", exp_read(r1), exp_read(r2), pend_q.size() > 0, m_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
